sm4_crypto_core: RTL



---
 rtl/sm4_crypto_core.sv | 106 ++++++++++
 1 files changed

// File: rtl/sm4_crypto_core.sv
// sm4_crypto_core: iterative SM4 block cipher datapath, one round per clock,
// encrypt/decrypt selected per block by round-key order.

module sm4_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] b_o
);
   localparam logic [0:255][7:0] TBL = {
      8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
      8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
      8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
      8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
      8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
      8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
      8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
      8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
      8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
      8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
      8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
      8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
      8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
      8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
      8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
      8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
   };
   assign b_o = TBL[a_i];
endmodule

module sm4_crypto_core (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         sm4_enable_in,
   input  logic         key_exp_finished_in,
   input  logic [31:0]  rk00_in, rk01_in, rk02_in, rk03_in, rk04_in, rk05_in, rk06_in, rk07_in,
   input  logic [31:0]  rk08_in, rk09_in, rk10_in, rk11_in, rk12_in, rk13_in, rk14_in, rk15_in,
   input  logic [31:0]  rk16_in, rk17_in, rk18_in, rk19_in, rk20_in, rk21_in, rk22_in, rk23_in,
   input  logic [31:0]  rk24_in, rk25_in, rk26_in, rk27_in, rk28_in, rk29_in, rk30_in, rk31_in,
   input  logic         encdec_sel_in,
   input  logic [127:0] data_in,
   input  logic         data_valid_in,
   output logic         data_ready_out,
   output logic [127:0] result_out,
   output logic         result_valid_out
);
   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
   state_t         state_q;
   logic [127:0]   x_q, x_d, result_q;
   logic [4:0]     cnt_q, idx;
   logic           mode_q, valid_q;
   logic [1023:0]  rk_all;
   logic [31:0]    rk, a, b, l, xnew;
   assign rk_all = {rk31_in, rk30_in, rk29_in, rk28_in, rk27_in, rk26_in, rk25_in, rk24_in,
                    rk23_in, rk22_in, rk21_in, rk20_in, rk19_in, rk18_in, rk17_in, rk16_in,
                    rk15_in, rk14_in, rk13_in, rk12_in, rk11_in, rk10_in, rk09_in, rk08_in,
                    rk07_in, rk06_in, rk05_in, rk04_in, rk03_in, rk02_in, rk01_in, rk00_in};
   // 31-cnt is the bitwise complement of a 5-bit counter
   assign idx  = mode_q ? ~cnt_q : cnt_q;
   assign rk   = rk_all[{idx, 5'd0} +: 32];
   assign a    = x_q[95:64] ^ x_q[63:32] ^ x_q[31:0] ^ rk;
   genvar i;
   for (i = 0; i < 4; i++) begin : g_sb
      sm4_sbox u_sb (.a_i(a[8*i +: 8]), .b_o(b[8*i +: 8]));
   end
   assign l    = b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
   assign xnew = x_q[127:96] ^ l;
   assign x_d  = {x_q[95:0], xnew};
   assign data_ready_out   = (state_q == IDLE) && sm4_enable_in && key_exp_finished_in;
   assign result_out       = result_q;
   assign result_valid_out = valid_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         x_q      <= '0;
         cnt_q    <= '0;
         mode_q   <= 1'b0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else if (state_q != IDLE && !(sm4_enable_in && key_exp_finished_in)) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (data_valid_in && data_ready_out) begin
               x_q     <= data_in;
               cnt_q   <= '0;
               mode_q  <= encdec_sel_in;
               state_q <= ROUND;
            end
            ROUND: begin
               x_q   <= x_d;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  result_q <= {xnew, x_q[31:0], x_q[63:32], x_q[95:64]};
                  valid_q  <= 1'b1;
                  state_q  <= DONE;
               end
            end
            default: begin
               valid_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end
endmodule
